// File: rtl/cnn_weight_streamer_1x1.sv
`default_nettype none
// ============================================================================
// Module   : cnn_weight_streamer_1x1
// Purpose  : Reads CHANNEL_NUM_IN*CHANNEL_NUM_OUT weights from a synchronous
//            weight memory and emits them as a valid-qualified stream with
//            per-filter boundary markers and start/busy/done control.
// Revision : 1.0 - initial release
// ============================================================================
module cnn_weight_streamer_1x1 #(
    parameter int DATA_WIDTH      = 16,
    parameter int CHANNEL_NUM_IN  = 64,
    parameter int CHANNEL_NUM_OUT = 128,
    parameter int ADDR_WIDTH      = 14,
    parameter int BASE_ADDR       = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stall,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic [DATA_WIDTH-1:0] weight_out,
    output logic                  valid_weight_out,
    output logic                  filter_last,
    output logic                  busy,
    output logic                  done
);

    localparam int N     = CHANNEL_NUM_IN * CHANNEL_NUM_OUT;
    localparam int CNT_W = $clog2(N + 1);
    localparam int FIL_W = (CHANNEL_NUM_IN > 1) ? $clog2(CHANNEL_NUM_IN) : 1;

    localparam logic [CNT_W-1:0]      LAST_CNT  = CNT_W'(N - 1);
    localparam logic [FIL_W-1:0]      LAST_FIL  = FIL_W'(CHANNEL_NUM_IN - 1);
    localparam logic [ADDR_WIDTH-1:0] BASE_A    = ADDR_WIDTH'(BASE_ADDR);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]            state_q,     state_d;
    logic [ADDR_WIDTH-1:0] addr_q,      addr_d;
    logic [CNT_W-1:0]      cnt_q,       cnt_d;
    logic [FIL_W-1:0]      fil_q,       fil_d;
    logic                  rd_en_d1_q,  rd_en_d1_d;
    logic                  rd_last_d1_q, rd_last_d1_d;
    logic [DATA_WIDTH-1:0] weight_q,    weight_d;
    logic                  valid_q,     valid_d;
    logic                  last_q,      last_d;

    logic w_issue;
    logic w_last_read;
    logic w_fil_end;

    assign w_issue     = (state_q == ST_FETCH) && !stall;
    assign w_last_read = w_issue && (cnt_q == LAST_CNT);
    assign w_fil_end   = (fil_q == LAST_FIL);

    // Control FSM: address/count/filter-index sequencing of memory reads.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        fil_d   = fil_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                    addr_d  = BASE_A;
                    cnt_d   = '0;
                    fil_d   = '0;
                end
            end
            ST_FETCH: begin
                if (w_issue) begin
                    addr_d = addr_q + ADDR_WIDTH'(1);
                    cnt_d  = cnt_q + CNT_W'(1);
                    fil_d  = w_fil_end ? '0 : fil_q + FIL_W'(1);
                    if (w_last_read) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // The cycle in which no read is left in the first pipeline
                // stage is the one emitting the final valid; done follows it.
                if (!rd_en_d1_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Read pipeline: memory latency stage, then output register.
    always_comb begin
        rd_en_d1_d   = w_issue;
        rd_last_d1_d = w_issue && w_fil_end;
        valid_d      = rd_en_d1_q;
        last_d       = rd_last_d1_q;
        weight_d     = rd_en_d1_q ? mem_rd_data : weight_q;
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            addr_q       <= BASE_A;
            cnt_q        <= '0;
            fil_q        <= '0;
            rd_en_d1_q   <= 1'b0;
            rd_last_d1_q <= 1'b0;
            weight_q     <= '0;
            valid_q      <= 1'b0;
            last_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            fil_q        <= fil_d;
            rd_en_d1_q   <= rd_en_d1_d;
            rd_last_d1_q <= rd_last_d1_d;
            weight_q     <= weight_d;
            valid_q      <= valid_d;
            last_q       <= last_d;
        end
    end

    assign mem_rd_en        = w_issue;
    assign mem_addr         = addr_q;
    assign weight_out       = weight_q;
    assign valid_weight_out = valid_q;
    assign filter_last      = last_q;
    assign busy             = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
    assign done             = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_cnn_weight_streamer_1x1.sv
`default_nettype none
// ============================================================================
// Module   : tb_cnn_weight_streamer_1x1
// Purpose  : Directed self-checking bench for cnn_weight_streamer_1x1 with a
//            4x2 weight set; one instance at base 0, one at base 100.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cnn_weight_streamer_1x1;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        stall;

    logic        rd_en0, rd_en1;
    logic [13:0] addr0;
    logic [7:0]  addr1;
    logic [15:0] rdata0, rdata1;
    logic [15:0] wout0, wout1;
    logic        vld0, vld1, lst0, lst1, busy0, busy1, done0, done1;

    logic [15:0] mem [0:255];

    int nvec = 0;
    int nerr = 0;

    // per-cycle capture (index = cycle number after the start edge)
    logic        v0 [0:63];
    logic [15:0] w0 [0:63];
    logic        l0 [0:63];
    logic        d0 [0:63];
    logic        b0 [0:63];
    logic        r0 [0:63];
    logic [13:0] a0 [0:63];
    logic        v1 [0:63];
    logic [15:0] w1 [0:63];
    logic        l1 [0:63];
    logic        d1 [0:63];
    logic        r1 [0:63];
    logic [7:0]  a1 [0:63];

    always #5 clk = ~clk;

    cnn_weight_streamer_1x1 #(
        .DATA_WIDTH(16), .CHANNEL_NUM_IN(4), .CHANNEL_NUM_OUT(2),
        .ADDR_WIDTH(14), .BASE_ADDR(0)
    ) dut0 (
        .clk(clk), .reset(reset), .start(start), .stall(stall),
        .mem_rd_en(rd_en0), .mem_addr(addr0), .mem_rd_data(rdata0),
        .weight_out(wout0), .valid_weight_out(vld0), .filter_last(lst0),
        .busy(busy0), .done(done0)
    );

    cnn_weight_streamer_1x1 #(
        .DATA_WIDTH(16), .CHANNEL_NUM_IN(4), .CHANNEL_NUM_OUT(2),
        .ADDR_WIDTH(8), .BASE_ADDR(100)
    ) dut1 (
        .clk(clk), .reset(reset), .start(start), .stall(stall),
        .mem_rd_en(rd_en1), .mem_addr(addr1), .mem_rd_data(rdata1),
        .weight_out(wout1), .valid_weight_out(vld1), .filter_last(lst1),
        .busy(busy1), .done(done1)
    );

    // synchronous weight memories, one read port per instance
    always @(posedge clk) begin
        if (rd_en0) rdata0 <= mem[addr0[7:0]];
        if (rd_en1) rdata1 <= mem[addr1];
    end

    // Pulses start in cycle 0 (caller sits just after an edge), then runs
    // ncyc cycles applying per-cycle start/stall bits and capturing outputs.
    task automatic run(input int ncyc, input logic [63:0] stall_bits,
                       input logic [63:0] start_bits);
        start = 1'b1;
        stall = 1'b0;
        for (int k = 1; k <= ncyc; k++) begin
            @(posedge clk); #1;
            start = start_bits[k];
            stall = stall_bits[k];
            @(negedge clk);
            v0[k] = vld0;  w0[k] = wout0; l0[k] = lst0; d0[k] = done0;
            b0[k] = busy0; r0[k] = rd_en0; a0[k] = addr0;
            v1[k] = vld1;  w1[k] = wout1; l1[k] = lst1; d1[k] = done1;
            r1[k] = rd_en1; a1[k] = addr1;
        end
        @(posedge clk); #1;
        start = 1'b0;
        stall = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; stall = 1'b0;
        #12;
        nvec++; if (vld0 !== 1'b0)    begin nerr++; $display("FAIL reset_valid got %b want 0", vld0); end
        nvec++; if (wout0 !== 16'd0)  begin nerr++; $display("FAIL reset_weight got %0d want 0", wout0); end
        nvec++; if (lst0 !== 1'b0)    begin nerr++; $display("FAIL reset_last got %b want 0", lst0); end
        nvec++; if (busy0 !== 1'b0)   begin nerr++; $display("FAIL reset_busy got %b want 0", busy0); end
        nvec++; if (done0 !== 1'b0)   begin nerr++; $display("FAIL reset_done got %b want 0", done0); end
        nvec++; if (rd_en0 !== 1'b0)  begin nerr++; $display("FAIL reset_rd_en got %b want 0", rd_en0); end
        nvec++; if (addr0 !== 14'd0)  begin nerr++; $display("FAIL reset_addr got %0d want 0", addr0); end
        nvec++; if (addr1 !== 8'd100) begin nerr++; $display("FAIL reset_addr_base got %0d want 100", addr1); end
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        run(14, 64'h0, 64'h0);
        for (int k = 1; k <= 14; k++) begin
            logic ev;
            ev = (k >= 3) && (k <= 10);
            nvec++; if (v0[k] !== ev) begin nerr++; $display("FAIL basic_valid c%0d got %b want %b", k, v0[k], ev); end
            if (ev) begin
                nvec++; if (w0[k] !== 16'(k - 2)) begin nerr++; $display("FAIL basic_weight c%0d got %0d want %0d", k, w0[k], k - 2); end
                nvec++; if (l0[k] !== ((k - 2) % 4 == 0)) begin nerr++; $display("FAIL basic_last c%0d got %b want %b", k, l0[k], ((k - 2) % 4 == 0)); end
            end else begin
                nvec++; if (l0[k] !== 1'b0) begin nerr++; $display("FAIL basic_last_idle c%0d got %b want 0", k, l0[k]); end
            end
            if (k > 10) begin
                nvec++; if (w0[k] !== 16'd8) begin nerr++; $display("FAIL basic_hold c%0d got %0d want 8", k, w0[k]); end
            end
            nvec++; if (d0[k] !== (k == 11)) begin nerr++; $display("FAIL basic_done c%0d got %b want %b", k, d0[k], (k == 11)); end
            nvec++; if (b0[k] !== (k <= 10)) begin nerr++; $display("FAIL basic_busy c%0d got %b want %b", k, b0[k], (k <= 10)); end
            nvec++; if (r0[k] !== (k <= 8)) begin nerr++; $display("FAIL basic_rd_en c%0d got %b want %b", k, r0[k], (k <= 8)); end
            if (k <= 8) begin
                nvec++; if (a0[k] !== 14'(k - 1)) begin nerr++; $display("FAIL basic_addr c%0d got %0d want %0d", k, a0[k], k - 1); end
            end
        end
    endtask

    task automatic test_stall();
        logic [63:0] exp_rd;
        logic [63:0] exp_v;
        int nxt;
        int rcnt;
        exp_rd = 64'hFC6;   // cycles 1,2,6..11
        exp_v  = 64'h3F18;  // cycles 3,4,8..13
        nxt  = 1;
        rcnt = 0;
        run(16, 64'h38, 64'h0);
        for (int k = 1; k <= 16; k++) begin
            nvec++; if (r0[k] !== exp_rd[k]) begin nerr++; $display("FAIL stall_rd_en c%0d got %b want %b", k, r0[k], exp_rd[k]); end
            if (k <= 11) begin
                nvec++; if (a0[k] !== 14'(rcnt)) begin nerr++; $display("FAIL stall_addr c%0d got %0d want %0d", k, a0[k], rcnt); end
            end
            if (exp_rd[k]) rcnt++;
            nvec++; if (v0[k] !== exp_v[k]) begin nerr++; $display("FAIL stall_valid c%0d got %b want %b", k, v0[k], exp_v[k]); end
            if (exp_v[k]) begin
                nvec++; if (w0[k] !== 16'(nxt)) begin nerr++; $display("FAIL stall_weight c%0d got %0d want %0d", k, w0[k], nxt); end
                nvec++; if (l0[k] !== (nxt % 4 == 0)) begin nerr++; $display("FAIL stall_last c%0d got %b want %b", k, l0[k], (nxt % 4 == 0)); end
                nxt++;
            end
            nvec++; if (d0[k] !== (k == 14)) begin nerr++; $display("FAIL stall_done c%0d got %b want %b", k, d0[k], (k == 14)); end
            nvec++; if (b0[k] !== (k <= 13)) begin nerr++; $display("FAIL stall_busy c%0d got %b want %b", k, b0[k], (k <= 13)); end
        end
    endtask

    task automatic test_start_ignored();
        int nv;
        int nd;
        nv = 0;
        nd = 0;
        run(26, 64'h0, 64'h1804);   // extra starts in cycles 2, 11 and 12
        for (int k = 1; k <= 26; k++) begin
            logic ev;
            ev = ((k >= 3) && (k <= 10)) || ((k >= 15) && (k <= 22));
            nvec++; if (v0[k] !== ev) begin nerr++; $display("FAIL busy_start_valid c%0d got %b want %b", k, v0[k], ev); end
            if (v0[k] === 1'b1) begin
                nvec++; if (w0[k] !== 16'((nv % 8) + 1)) begin nerr++; $display("FAIL busy_start_weight c%0d got %0d want %0d", k, w0[k], (nv % 8) + 1); end
                nv++;
            end
            if (d0[k] === 1'b1) nd++;
            nvec++; if (d0[k] !== ((k == 11) || (k == 23))) begin nerr++; $display("FAIL busy_start_done c%0d got %b want %b", k, d0[k], ((k == 11) || (k == 23))); end
        end
        nvec++; if (nv != 16) begin nerr++; $display("FAIL busy_start_count got %0d want 16", nv); end
        nvec++; if (nd != 2)  begin nerr++; $display("FAIL busy_start_dones got %0d want 2", nd); end
    endtask

    task automatic test_reset_mid();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        nvec++; if (vld0 !== 1'b1 || wout0 !== 16'd3) begin nerr++; $display("FAIL rstmid_pre got v=%b w=%0d want v=1 w=3", vld0, wout0); end
        #1 reset = 1'b0;
        #1;
        nvec++; if (vld0 !== 1'b0)   begin nerr++; $display("FAIL rstmid_valid got %b want 0", vld0); end
        nvec++; if (busy0 !== 1'b0)  begin nerr++; $display("FAIL rstmid_busy got %b want 0", busy0); end
        nvec++; if (done0 !== 1'b0)  begin nerr++; $display("FAIL rstmid_done got %b want 0", done0); end
        nvec++; if (rd_en0 !== 1'b0) begin nerr++; $display("FAIL rstmid_rd_en got %b want 0", rd_en0); end
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            nvec++; if (vld0 !== 1'b0 || done0 !== 1'b0) begin nerr++; $display("FAIL rstmid_quiet got v=%b d=%b want 0 0", vld0, done0); end
        end
        @(posedge clk); #1;
        run(12, 64'h0, 64'h0);
        for (int k = 1; k <= 12; k++) begin
            logic ev;
            ev = (k >= 3) && (k <= 10);
            nvec++; if (v0[k] !== ev) begin nerr++; $display("FAIL rstmid_re_valid c%0d got %b want %b", k, v0[k], ev); end
            if (ev) begin
                nvec++; if (w0[k] !== 16'(k - 2)) begin nerr++; $display("FAIL rstmid_re_weight c%0d got %0d want %0d", k, w0[k], k - 2); end
            end
            nvec++; if (d0[k] !== (k == 11)) begin nerr++; $display("FAIL rstmid_re_done c%0d got %b want %b", k, d0[k], (k == 11)); end
        end
    endtask

    task automatic test_offset();
        run(12, 64'h0, 64'h0);
        for (int k = 1; k <= 12; k++) begin
            logic ev;
            ev = (k >= 3) && (k <= 10);
            nvec++; if (r1[k] !== (k <= 8)) begin nerr++; $display("FAIL offset_rd_en c%0d got %b want %b", k, r1[k], (k <= 8)); end
            if (k <= 8) begin
                nvec++; if (a1[k] !== 8'(99 + k)) begin nerr++; $display("FAIL offset_addr c%0d got %0d want %0d", k, a1[k], 99 + k); end
            end
            nvec++; if (v1[k] !== ev) begin nerr++; $display("FAIL offset_valid c%0d got %b want %b", k, v1[k], ev); end
            if (ev) begin
                nvec++; if (w1[k] !== 16'(k + 98)) begin nerr++; $display("FAIL offset_weight c%0d got %0d want %0d", k, w1[k], k + 98); end
                nvec++; if (l1[k] !== ((k - 2) % 4 == 0)) begin nerr++; $display("FAIL offset_last c%0d got %b want %b", k, l1[k], ((k - 2) % 4 == 0)); end
            end
            nvec++; if (d1[k] !== (k == 11)) begin nerr++; $display("FAIL offset_done c%0d got %b want %b", k, d1[k], (k == 11)); end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'(i + 1);
        test_reset();
        test_basic();
        test_stall();
        test_start_ignored();
        test_reset_mid();
        test_offset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cnn_weight_streamer_1x1.md
Name: cnn_weight_streamer_1x1

Overview:
- Producer side of the 1x1-conv weight interface: fetches CHANNEL_NUM_IN*CHANNEL_NUM_OUT weights from a synchronous weight memory and drives them as a valid-qualified stream.
- Its output stream feeds the conv block's valid_weight_in/weight_in ports.
- Supports start/busy/done control, a stall input for pacing, and per-filter boundary markers.

Parameters:
DATA_WIDTH, 16, weight word width
CHANNEL_NUM_IN, 64, weights per output filter
CHANNEL_NUM_OUT, 128, number of output filters
ADDR_WIDTH, 14, weight memory address width (must satisfy 2^ADDR_WIDTH >= BASE_ADDR + N)
BASE_ADDR, 0, address of first weight
Derived: N = CHANNEL_NUM_IN*CHANNEL_NUM_OUT (total weights)

Ports:
clk  input  1  single clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  one-cycle request to stream one full weight set; sampled only in IDLE
stall  input  1  when high, no new memory read is issued this cycle
mem_rd_en  output  1  memory read enable; combinational: (state==FETCH) && !stall
mem_addr  output  ADDR_WIDTH  registered read address
mem_rd_data  input  DATA_WIDTH  memory data, valid the cycle after mem_rd_en
weight_out  output  DATA_WIDTH  streamed weight (registered)
valid_weight_out  output  1  weight_out qualifier
filter_last  output  1  high with the valid of the last weight of each filter (index CHANNEL_NUM_IN-1 mod CHANNEL_NUM_IN)
busy  output  1  high in FETCH and DRAIN
done  output  1  one-cycle pulse, cycle after the final valid_weight_out

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; mem_addr=BASE_ADDR; read counter=0; pipeline valid bits=0.
  - weight_out=0, valid_weight_out=0, filter_last=0, busy=0, done=0.
- States:
  - IDLE: start=1 -> FETCH; mem_addr<=BASE_ADDR; read count<=0.
  - FETCH: each cycle with stall=0, a read is issued at mem_addr; mem_addr and count increment. When the issued read is index N-1 -> DRAIN. stall=1 holds address and count.
  - DRAIN: waits until both pipeline stages are empty, i.e. the final valid_weight_out has been emitted -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- Read pipeline:
  - rd_en_d1 <= mem_rd_en.
  - rd_last_d1 marks a filter boundary: (issued index mod CHANNEL_NUM_IN)==CHANNEL_NUM_IN-1.
  - Output register: weight_out<=mem_rd_data, valid_weight_out<=rd_en_d1, filter_last<=rd_last_d1.
  - A read issued in cycle t appears on valid_weight_out in cycle t+2.
  - stall does not hold back in-flight reads; up to 2 weights still emerge after stall rises.
- Latency: start sampled at edge e; first mem_rd_en in cycle e+1; first valid_weight_out in cycle e+3. With no stall, N consecutive valid cycles; done in cycle e+N+3.
- weight_out holds its last value when valid_weight_out=0. Consumers must qualify with valid.
- start while busy or in DONE: ignored; no queuing.
- Exactly N valids per start, in address order BASE_ADDR..BASE_ADDR+N-1, regardless of the stall pattern.
- Counter width: $clog2(N+1). Filter index counter wraps at CHANNEL_NUM_IN.
- Reset asserted mid-stream: immediate return to IDLE. No further valids, no done pulse. A new start after release restarts from BASE_ADDR.
- stall=1 in IDLE/DRAIN/DONE: no effect.

Test Plan:
- Setup for all scenarios: CHANNEL_NUM_IN=4, CHANNEL_NUM_OUT=2, BASE_ADDR=0; memory mem[i]=i+1.
- Basic stream:
  - Stimulus: start pulse at edge 0, stall=0.
  - Response: valid_weight_out high cycles 3..10; weight_out 1..8; filter_last high with weights 4 and 8; done=1 cycle 11; busy high cycles 1..10.
- Stall mid-fetch:
  - Stimulus: stall=1 during cycles 3-5.
  - Response: reads issued cycles 1,2,6..11; valids cycles 3,4,8..13; values still 1..8 in order; done cycle 14.
- Start ignored while busy:
  - Stimulus: extra start pulses in cycles 2 and 11.
  - Response: exactly 8 valids and one done pulse; a start in cycle 12 (IDLE) begins a second identical stream.
- Reset mid-stream:
  - Stimulus: reset=0 asynchronously in cycle 5.
  - Response: valid_weight_out, busy, done and mem_rd_en fall immediately; no done. After release plus start, stream restarts at weight 1.
- Offset base:
  - Stimulus: BASE_ADDR=100, 2^ADDR_WIDTH large enough.
  - Response: mem_addr 100..107; weights mem[100..107] in order; filter_last on the 4th and 8th weights.
